debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
//
// PURPOSE
//  Multi-channel counter-based debouncer for protoboard switches and buttons.
//  Each channel synchronises its raw input and filters it in both directions.
//  The output changes only after the input has held its new level for
//  STABLE_COUNT consecutive qualified samples. Shorter glitches are rejected.
//  Sits between the protoboard input pins and all downstream logic.
//
// PARAMETERS
//  N_CH          4    number of independent channels (>=1)
//  STABLE_COUNT  4    consecutive differing samples required to change output (>=1)
//  INIT_LEVEL    0    reset level of synchroniser and d_out, all channels (0/1)
//  localparam CNT_W = $clog2(STABLE_COUNT+1)   width of per-channel counter
//
// PORTS
//  sample_clk  in   1     single clock; all state updates on its rising edge
//  rst         in   1     synchronous, active-high reset
//  sample_en   in   1     sample qualifier; state advances only when high
//  d_in        in   N_CH  raw asynchronous inputs
//  d_out       out  N_CH  debounced levels
//  rise        out  N_CH  1-cycle pulse when d_out goes 0->1 (see CONFIGURATION)
//  fall        out  N_CH  1-cycle pulse when d_out goes 1->0 (see CONFIGURATION)
//
// BEHAVIOUR
//  - rst=1 at an edge: sync[1:0] and d_out go to INIT_LEVEL; cnt, rise and fall go to 0.
//    This holds regardless of sample_en. Reset mid-count discards the count.
//  - Per channel, with sample_en=1: sync0<=d_in, sync1<=sync0 (2-FF synchroniser).
//  - Compare uses registered sync1 against d_out:
//      sync1==d_out                      -> cnt<=0
//      sync1!=d_out, cnt<STABLE_COUNT-1  -> cnt<=cnt+1
//      sync1!=d_out, cnt==STABLE_COUNT-1 -> d_out<=sync1, cnt<=0, pulse rise/fall
//  - Latency: a clean step on d_in before edge k appears on d_out after edge
//    k+STABLE_COUNT+1, i.e. STABLE_COUNT+2 qualified edges.
//  - A glitch of fewer than STABLE_COUNT qualified samples at sync1 leaves d_out
//    unchanged. Its count is cleared as soon as sync1 matches d_out again.
//  - sample_en=0: sync, cnt and d_out hold; rise and fall are 0 that cycle.
//    Unqualified cycles neither count nor break a run.
//  - rise and fall are registered, high for exactly one sample_clk cycle.
//    They assert in the same cycle d_out changes and are never both high.
//  - Channels are fully independent; simultaneous events on many channels are legal.
//  - cnt never exceeds STABLE_COUNT-1, so no wrap-around.
//  - STABLE_COUNT=1: output follows sync1 with 1-cycle delay (no filtering).
//
// CONFIGURATION
//  DEBOUNCE_EDGE_EN defined: rise and fall are generated as described above.
//  DEBOUNCE_EDGE_EN undefined: rise and fall are tied to 0 and their logic is
//    not built. Ports remain, and d_out behaviour is identical.
//
// TESTING
//  (all cases: N_CH=4, STABLE_COUNT=4, INIT_LEVEL=0, sample_en=1 unless stated)
//  1. rst high 2 cycles, then low -> d_out=4'h0, rise=fall=0.
//     d_in[0] 0->1 before edge 0 -> d_out[0]=1 after edge 5; rise[0]=1 for that
//     single cycle only.
//  2. d_in[1] high for 3 cycles, then low -> d_out[1] stays 0; rise[1] never asserts.
//  3. d_in[2] 1 then 0 after d_out[2]=1 -> d_out[2]=0 six edges later; fall[2]
//     pulses once.
//  4. sample_en toggling 1,0,1,0... with d_in[3] stepped high -> d_out[3] rises
//     after 6 qualified edges (11 clocks); no pulse in sample_en=0 cycles.
//  5. rst asserted while cnt=2 on channel 0 -> cnt=0, d_out[0]=0.
//     Input held high after release -> a full 6-edge latency is required again.
//  6. Build without DEBOUNCE_EDGE_EN, repeat case 1 -> same d_out timing; rise=fall=0 always.

Source files
------------

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : Multi-channel counter-based debouncer. Each channel passes
//                its raw input through a 2-FF synchroniser and then filters
//                it in both directions: d_out only takes a new level after
//                the synchronised input has differed from d_out for
//                STABLE_COUNT consecutive qualified samples. Shorter glitches
//                are rejected and their partial count is discarded.
//
//  Ports       : sample_clk  in   1     single clock, rising edge
//                rst         in   1     synchronous, active-high reset
//                sample_en   in   1     sample qualifier, state advances when high
//                d_in        in   N_CH  raw asynchronous inputs
//                d_out       out  N_CH  debounced levels
//                rise        out  N_CH  1-cycle pulse when d_out goes 0->1
//                fall        out  N_CH  1-cycle pulse when d_out goes 1->0
//
//  Parameters  : N_CH          number of independent channels (>=1)
//                STABLE_COUNT  consecutive differing samples to change d_out (>=1)
//                INIT_LEVEL    reset level of synchroniser and d_out (0/1)
//
//  Build option: DEBOUNCE_EDGE_EN - when defined, rise/fall pulses are built.
//                When undefined, rise/fall are tied to 0 and d_out behaviour
//                is unchanged.
//
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int STABLE_COUNT = 4,
  parameter bit INIT_LEVEL   = 1'b0
) (
  input  logic            sample_clk,
  input  logic            rst,
  input  logic            sample_en,
  input  logic [N_CH-1:0] d_in,
  output logic [N_CH-1:0] d_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  localparam int CNT_W = $clog2(STABLE_COUNT + 1);
  // Terminal count: reaching it while still differing commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             sync0;
    logic             sync1;
    logic             out_q;
    logic [CNT_W-1:0] cnt;
    logic             differs;
    logic             at_last;

    // Comparison uses the registered synchroniser output, never sync0,
    // so metastability on sync0 cannot reach the counter.
    assign differs = (sync1 != out_q);
    assign at_last = (cnt == CNT_LAST);

    always_ff @(posedge sample_clk) begin
      if (rst) begin
        sync0 <= INIT_LEVEL;
        sync1 <= INIT_LEVEL;
        out_q <= INIT_LEVEL;
        cnt   <= '0;
      end else if (sample_en) begin
        sync0 <= d_in[i];
        sync1 <= sync0;
        if (!differs) begin
          // Any matching sample breaks the run.
          cnt <= '0;
        end else if (at_last) begin
          out_q <= sync1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign d_out[i] = out_q;

`ifdef DEBOUNCE_EDGE_EN
    logic commit;
    logic rise_q;
    logic fall_q;

    // Same condition that updates out_q, so the pulse lines up with the
    // cycle in which d_out changes. Unqualified cycles clear the pulse.
    assign commit = sample_en & differs & at_last;

    always_ff @(posedge sample_clk) begin
      if (rst) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= commit &  sync1;
        fall_q <= commit & ~sync1;
      end
    end

    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
`endif
  end

`ifndef DEBOUNCE_EDGE_EN
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_multi
//  Description : Self-checking bench for debounce_multi (N_CH=4,
//                STABLE_COUNT=4, INIT_LEVEL=0). Per-cycle vectors hold the
//                inputs applied before an edge and the outputs expected just
//                after it; expected values go through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_debounce_multi;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            sample_en;
  logic [N_CH-1:0] d_in;
  logic [N_CH-1:0] d_out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic            rst;
    logic            en;
    logic [N_CH-1:0] din;
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
  } vec_t;

  typedef struct {
    logic [N_CH-1:0] out;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    int              idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   vec_no = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH         (4),
    .STABLE_COUNT (4),
    .INIT_LEVEL   (1'b0)
  ) dut (
    .sample_clk (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .d_in       (d_in),
    .d_out      (d_out),
    .rise       (rise),
    .fall       (fall)
  );

  // Push n identical cycles into the vector table.
  task automatic add(input logic r, input logic en, input logic [3:0] din,
                     input logic [3:0] out, input logic [3:0] ri,
                     input logic [3:0] fa, input int n);
    vec_t v;
    v.rst = r; v.en = en; v.din = din; v.out = out; v.rise = ri; v.fall = fa;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, req);
    end
  endtask

  // Drive one cycle at the falling edge, queue its expectation, and compare
  // once the rising edge has settled.
  task automatic step(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst       = v.rst;
    sample_en = v.en;
    d_in      = v.din;
    e.out  = v.out;
`ifdef DEBOUNCE_EDGE_EN
    e.rise = v.rise;
    e.fall = v.fall;
`else
    e.rise = '0;
    e.fall = '0;
`endif
    e.idx = vec_no;
    sb.push_back(e);
    vec_no++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty at vec %0d", vec_no);
    end else begin
      got = sb.pop_front();
      check("d_out", got.idx, d_out, got.out);
      check("rise",  got.idx, rise,  got.rise);
      check("fall",  got.idx, fall,  got.fall);
    end
  endtask

  task automatic hand(input logic r, input logic en, input logic [3:0] din,
                      input logic [3:0] out, input logic [3:0] ri,
                      input logic [3:0] fa, input int n);
    vec_t v;
    v.rst = r; v.en = en; v.din = din; v.out = out; v.rise = ri; v.fall = fa;
    for (int k = 0; k < n; k++) step(v);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b1; d_in = '0;

    // Reset, then a clean step on ch0: d_out after the 6th edge, one pulse.
    add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    add(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 5);
    add(0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 1);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    // 3-cycle glitch on ch1: counter peaks one short, output holds.
    add(0, 1, 4'h3, 4'h1, 4'h0, 4'h0, 3);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 4);
    // 4-cycle pulse on ch1: just long enough, so it rises then falls.
    add(0, 1, 4'h3, 4'h1, 4'h0, 4'h0, 4);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    add(0, 1, 4'h1, 4'h3, 4'h2, 4'h0, 1);
    add(0, 1, 4'h1, 4'h3, 4'h0, 4'h0, 3);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h2, 1);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 2);
    // ch2 goes high, then low: fall six edges after the input drops.
    add(0, 1, 4'h5, 4'h1, 4'h0, 4'h0, 5);
    add(0, 1, 4'h5, 4'h5, 4'h4, 4'h0, 1);
    add(0, 1, 4'h1, 4'h5, 4'h0, 4'h0, 5);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h4, 1);
    add(0, 1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
    // sample_en alternating: ch3 rises on the 11th clock (6th qualified).
    for (int k = 0; k < 10; k++)
      add(0, (k % 2 == 0), 4'h9, 4'h1, 4'h0, 4'h0, 1);
    add(0, 1, 4'h9, 4'h9, 4'h8, 4'h0, 1);
    add(0, 0, 4'h9, 4'h9, 4'h0, 4'h0, 1);
    add(0, 1, 4'h9, 4'h9, 4'h0, 4'h0, 1);

    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-count on ch0 (cnt=2), asserted while sample_en is low:
    // the count is lost and the full 6-edge latency applies again.
    hand(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    hand(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4);
    hand(1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1);
    hand(0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 5);
    hand(0, 1, 4'h1, 4'h1, 4'h1, 4'h0, 1);
    // Simultaneous events on several channels in both directions.
    hand(0, 1, 4'hF, 4'h1, 4'h0, 4'h0, 5);
    hand(0, 1, 4'hF, 4'hF, 4'hE, 4'h0, 1);
    hand(0, 1, 4'h0, 4'hF, 4'h0, 4'h0, 5);
    hand(0, 1, 4'h0, 4'h0, 4'h0, 4'hF, 1);
    hand(0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 2);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
